dual_mem_reader: RTL and testbench

DUAL_MEM_READER -- requirements
Module: dual_mem_reader

---
 rtl/dual_mem_reader.sv | 162 ++++++++++++++++
 tb/tb_dual_mem_reader.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dual_mem_reader.sv
// Burst reader: streams a run of consecutive RAM words (address wraps at the top of the RAM)
// into a ready/valid stream through a 2-entry skid FIFO.
module dual_mem_reader #(
    parameter int RAM_WIDTH = 64,
    parameter int ADDR_SIZE = 10
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [ADDR_SIZE-1:0] base_addr,
    input  logic [ADDR_SIZE:0]   length,
    input  logic [RAM_WIDTH-1:0] mem_data,
    output logic                 mem_op_en,
    output logic                 mem_read,
    output logic [ADDR_SIZE-1:0] mem_rd_address,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [RAM_WIDTH-1:0] out_data,
    output logic                 out_last,
    output logic                 busy,
    output logic                 done
);

    localparam logic [ADDR_SIZE:0] MAX_LEN = {1'b1, {ADDR_SIZE{1'b0}}};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [ADDR_SIZE-1:0] addr_q, addr_d;
    logic [ADDR_SIZE-1:0] rd_addr_q, rd_addr_d;
    logic [ADDR_SIZE:0]   remaining_q, remaining_d;
    logic                 in_flight_q, in_flight_d;
    logic                 flight_last_q, flight_last_d;
    logic                 done_q, done_d;
    logic [1:0]           count_q, count_d;
    logic                 wr_ptr_q, rd_ptr_q;
    logic [RAM_WIDTH-1:0] fifo_data_q [2];
    logic                 fifo_last_q [2];

    logic [ADDR_SIZE:0]   len_sat;
    logic                 issue;
    logic                 push;
    logic                 pop;
    logic [2:0]           occupancy;

    assign len_sat = (length > MAX_LEN) ? MAX_LEN : length;
    assign push    = in_flight_q;
    assign pop     = (count_q != 2'd0) && out_ready;

    // Slots claimed after this cycle's pop; a new read may only take the last free slot.
    assign occupancy = {1'b0, count_q} + {2'b00, in_flight_q} - {2'b00, pop};
    assign issue     = (state_q == RUN) && (remaining_q != '0) && (occupancy <= 3'd1);

    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        rd_addr_d     = rd_addr_q;
        remaining_d   = remaining_q;
        in_flight_d   = 1'b0;
        flight_last_d = flight_last_q;
        done_d        = 1'b0;
        count_d       = count_q + {1'b0, push} - {1'b0, pop};

        case (state_q)
            IDLE: begin
                if (start) begin
                    if (len_sat != '0) begin
                        addr_d      = base_addr;
                        remaining_d = len_sat;
                        state_d     = RUN;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            RUN: begin
                if (issue && (remaining_q == 1)) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (pop && fifo_last_q[rd_ptr_q]) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (issue) begin
            addr_d        = addr_q + 1'b1;
            rd_addr_d     = addr_q;
            remaining_d   = remaining_q - 1'b1;
            in_flight_d   = 1'b1;
            flight_last_d = (remaining_q == 1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q        <= '0;
            rd_addr_q     <= '0;
            remaining_q   <= '0;
            in_flight_q   <= 1'b0;
            flight_last_q <= 1'b0;
            done_q        <= 1'b0;
            count_q       <= 2'd0;
            wr_ptr_q      <= 1'b0;
            rd_ptr_q      <= 1'b0;
        end else begin
            addr_q        <= addr_d;
            rd_addr_q     <= rd_addr_d;
            remaining_q   <= remaining_d;
            in_flight_q   <= in_flight_d;
            flight_last_q <= flight_last_d;
            done_q        <= done_d;
            count_q       <= count_d;
            if (push) begin
                wr_ptr_q <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
        end
    end

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_fifo
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    fifo_data_q[gi] <= '0;
                    fifo_last_q[gi] <= 1'b0;
                end else if (push && (wr_ptr_q == 1'(gi))) begin
                    fifo_data_q[gi] <= mem_data;
                    fifo_last_q[gi] <= flight_last_q;
                end
            end
        end
    endgenerate

    assign mem_op_en      = (state_q != IDLE);
    assign mem_read       = issue;
    assign mem_rd_address = issue ? addr_q : rd_addr_q;
    assign out_valid      = (count_q != 2'd0);
    assign out_data       = fifo_data_q[rd_ptr_q];
    assign out_last       = out_valid && fifo_last_q[rd_ptr_q];
    assign busy           = (state_q != IDLE);
    assign done           = done_q;

endmodule

// File: tb/tb_dual_mem_reader.sv
// Randomized bench for dual_mem_reader: a RAM model with 1-cycle read latency, a queue-based
// reference of the expected address/word sequence, and per-burst timing and count checks.
module tb_dual_mem_reader;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [9:0]  base_addr;
    logic [10:0] length;
    logic [63:0] mem_data;
    logic        mem_op_en;
    logic        mem_read;
    logic [9:0]  mem_rd_address;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_data;
    logic        out_last;
    logic        busy;
    logic        done;

    dual_mem_reader #(.RAM_WIDTH(64), .ADDR_SIZE(10)) dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .base_addr      (base_addr),
        .length         (length),
        .mem_data       (mem_data),
        .mem_op_en      (mem_op_en),
        .mem_read       (mem_read),
        .mem_rd_address (mem_rd_address),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_data       (out_data),
        .out_last       (out_last),
        .busy           (busy),
        .done           (done)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    logic [63:0] mem_arr [1024];
    logic [9:0]  exp_addr_q [$];
    logic [63:0] exp_data_q [$];
    logic        exp_last_q [$];

    int   read_count, xfer_count, done_count;
    int   first_read_cyc, last_read_cyc, last_xfer_cyc, done_cyc;
    int   max_out, stall_viol;
    logic first_read_busy, first_read_op_en, busy_seen;
    logic prev_valid, prev_ready, prev_last;
    logic [63:0] prev_data;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // RAM model: data valid in the cycle after the read strobe; junk otherwise.
    always @(posedge clk) begin
        if (mem_read) mem_data <= mem_arr[mem_rd_address];
        else          mem_data <= {$urandom, $urandom};
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (mem_read) begin
                if (exp_addr_q.size() == 0) check_eq("extra_read", 64'(mem_rd_address), 64'h0);
                else check_eq("rd_addr", 64'(mem_rd_address), 64'(exp_addr_q.pop_front()));
                read_count++;
                if (read_count == 1) begin
                    first_read_cyc   = cyc;
                    first_read_busy  = busy;
                    first_read_op_en = mem_op_en;
                end
                last_read_cyc = cyc;
            end
            if (out_valid && out_ready) begin
                if (exp_data_q.size() == 0) begin
                    check_eq("extra_word", out_data, 64'h0);
                end else begin
                    check_eq("data", out_data, exp_data_q.pop_front());
                    check_eq("last", 64'(out_last), 64'(exp_last_q.pop_front()));
                end
                xfer_count++;
                last_xfer_cyc = cyc;
            end
            if (done) begin
                done_count++;
                done_cyc = cyc;
            end
            if (busy) busy_seen = 1'b1;
            if (read_count - xfer_count > max_out) max_out = read_count - xfer_count;
            if (prev_valid && !prev_ready &&
                !(out_valid && out_data === prev_data && out_last === prev_last)) begin
                stall_viol++;
            end
            prev_valid = out_valid;
            prev_ready = out_ready;
            prev_data  = out_data;
            prev_last  = out_last;
        end else begin
            prev_valid = 1'b0;
        end
    end

    task automatic clear_stats();
        read_count = 0; xfer_count = 0; done_count = 0;
        first_read_cyc = -1; last_read_cyc = -1; last_xfer_cyc = -1; done_cyc = -1;
        max_out = 0; stall_viol = 0;
        first_read_busy = 1'b0; first_read_op_en = 1'b0; busy_seen = 1'b0;
    endtask

    task automatic load_expected(input logic [9:0] b, input int eff);
        logic [9:0] a;
        exp_addr_q.delete(); exp_data_q.delete(); exp_last_q.delete();
        for (int i = 0; i < eff; i++) begin
            a = b + 10'(i);
            exp_addr_q.push_back(a);
            exp_data_q.push_back(mem_arr[a]);
            exp_last_q.push_back(i == eff - 1);
        end
    endtask

    task automatic run_burst(input logic [9:0] b, input logic [10:0] len,
                             input bit rnd_ready, input bit poke_start);
        int eff, budget, start_cyc;
        eff = (len > 11'd1024) ? 1024 : int'(len);
        load_expected(b, eff);
        clear_stats();
        out_ready = 1'b1;
        start     = 1'b1;
        base_addr = b;
        length    = len;
        start_cyc = cyc;
        @(posedge clk); #1;
        start  = 1'b0;
        budget = 4 * eff + 20;
        for (int k = 0; k < budget && done_count == 0; k++) begin
            out_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            if (poke_start && k == 6) begin
                start     = 1'b1;
                base_addr = b + 10'd100;
                length    = 11'd5;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
        end
        start     = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        $display("burst base=%03h len=%0d rnd=%0d poke=%0d: reads=%0d words=%0d done=%0d",
                 b, len, rnd_ready, poke_start, read_count, xfer_count, done_count);
        check_eq("done_count", 64'(done_count), 64'd1);
        check_eq("read_count", 64'(read_count), 64'(eff));
        check_eq("word_count", 64'(xfer_count), 64'(eff));
        check_eq("words_left", 64'(exp_data_q.size()), 64'd0);
        check_eq("busy_after", 64'(busy), 64'd0);
        check_eq("op_en_after", 64'(mem_op_en), 64'd0);
        if (eff > 0) begin
            check_eq("first_rd_lat", 64'(first_read_cyc), 64'(start_cyc + 1));
            check_eq("busy_at_rd", 64'(first_read_busy), 64'd1);
            check_eq("op_en_at_rd", 64'(first_read_op_en), 64'd1);
            check_eq("done_lat", 64'(done_cyc), 64'(last_xfer_cyc + 1));
            check_eq("max_outstanding_le2", 64'(max_out <= 2), 64'd1);
            check_eq("stall_stable", 64'(stall_viol), 64'd0);
            if (!rnd_ready) begin
                check_eq("rd_span", 64'(last_read_cyc - first_read_cyc), 64'(eff - 1));
                check_eq("xfer_span", 64'(last_xfer_cyc - first_read_cyc), 64'(eff + 1));
            end
        end else begin
            check_eq("len0_busy_seen", 64'(busy_seen), 64'd0);
            check_eq("len0_done_lat", 64'(done_cyc), 64'(start_cyc + 1));
        end
    endtask

    task automatic check_outputs_zero(input string tag);
        check_eq({tag, "_op_en"},  64'(mem_op_en), 64'd0);
        check_eq({tag, "_read"},   64'(mem_read), 64'd0);
        check_eq({tag, "_addr"},   64'(mem_rd_address), 64'd0);
        check_eq({tag, "_valid"},  64'(out_valid), 64'd0);
        check_eq({tag, "_data"},   out_data, 64'd0);
        check_eq({tag, "_last"},   64'(out_last), 64'd0);
        check_eq({tag, "_busy"},   64'(busy), 64'd0);
        check_eq({tag, "_done"},   64'(done), 64'd0);
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem_arr[i] = {$urandom, $urandom};
        clear_stats();
        rst = 1'b1; start = 1'b0; base_addr = '0; length = '0; out_ready = 1'b1;
        #1;
        check_outputs_zero("reset");
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk); #1;

        run_burst(10'h010, 11'd4, 1'b0, 1'b0);
        run_burst(10'h3FE, 11'd4, 1'b0, 1'b0);
        for (int t = 0; t < 3; t++) run_burst(10'($urandom), 11'd8, 1'b1, 1'b0);
        run_burst(10'h123, 11'd0, 1'b1, 1'b0);
        run_burst(10'h155, 11'd2047, 1'b0, 1'b0);

        // Reset in the middle of a 16-word burst.
        load_expected(10'h080, 16);
        clear_stats();
        start = 1'b1; base_addr = 10'h080; length = 11'd16; out_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 0; k < 100 && xfer_count < 3; k++) begin
            @(posedge clk); #1;
        end
        check_eq("pre_rst_words", 64'(xfer_count), 64'd3);
        rst = 1'b1;
        #1;
        $display("reset asserted after %0d words", xfer_count);
        check_outputs_zero("midrst");
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("midrst_no_done", 64'(done_count), 64'd0);
        check_eq("midrst_busy", 64'(busy), 64'd0);
        run_burst(10'h200, 11'd2, 1'b0, 1'b0);

        run_burst(10'h0A0, 11'd16, 1'b1, 1'b1);
        for (int t = 0; t < 10; t++) begin
            run_burst(10'($urandom), 11'($urandom_range(1, 40)), 1'b1, 1'b0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
